// File: rtl/control_sequencer_pkg.sv
// Shared ISA encoding, FSM state encoding and instruction field positions
// for the 8-bit CPU control sequencer.
package control_sequencer_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_LDI  = 2'b10;
    localparam logic [1:0] OP_HLT  = 2'b11;
    localparam logic [1:0] SUB_JMP = 2'b01;

    // Instruction layout: [7:6] op, [5:4] dst, [3:2] src, [1:0] sub
    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int DST_HI = 5;
    localparam int DST_LO = 4;
    localparam int SRC_HI = 3;
    localparam int SRC_LO = 2;
    localparam int SUB_HI = 1;
    localparam int SUB_LO = 0;

    localparam int NUM_REGS = 4;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_READ_SRC  = 3'd2,
        ST_FETCH_IMM = 3'd3,
        ST_WRITE_DST = 3'd4,
        ST_HALT      = 3'd5
    } state_t;

    function automatic logic [1:0] ir_op(input logic [7:0] ir);
        return ir[OP_HI:OP_LO];
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Program-memory fetch handshake plus register-bank RS/RW/Din/Dout lines.
interface control_sequencer_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_ready;
    logic [DW-1:0] mem_data;
    logic [3:0]    reg_rs;
    logic          reg_rw;
    logic [DW-1:0] reg_din;
    logic [DW-1:0] reg_dout;

    modport master (
        output mem_addr, mem_rd, reg_rs, reg_rw, reg_din,
        input  mem_ready, mem_data, reg_dout
    );

    modport slave (
        input  mem_addr, mem_rd, reg_rs, reg_rw, reg_din,
        output mem_ready, mem_data, reg_dout
    );
endinterface

// File: rtl/prog_counter.sv
// Program counter with load (priority) and increment; wraps modulo 2^AW.
module prog_counter #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    output logic [AW-1:0] pc
);

    logic [AW-1:0] pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= '0;
        end else if (load) begin
            pc_reg <= load_val;
        end else if (inc) begin
            pc_reg <= pc_reg + 1'b1;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/control_sequencer.sv
// Fetch/decode/execute FSM driving a 4-entry register bank.
// Optional JMP (op=00, sub=01) is enabled by defining CTRL_JMP_EN.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    control_sequencer_if.master bus,
    output logic [DW-1:0]     instr,
    output logic              halted
);

    state_t        state_reg;
    state_t        state_next;
    logic [DW-1:0] ir_reg;
    logic [DW-1:0] tmp_reg;

    logic          mem_rd_next;
    logic          rs_en;
    logic [1:0]    rs_idx;
    logic          rw_next;
    logic [DW-1:0] din_next;
    logic          pc_inc;
    logic          pc_load;
    logic          ir_load;
    logic          tmp_load;
    logic [DW-1:0] tmp_val;
    logic          is_jmp;
    logic [AW-1:0] pc;
    logic [3:0]    rs_onehot;

`ifdef CTRL_JMP_EN
    assign is_jmp = (ir_op(ir_reg) == OP_NOP) && (ir_reg[SUB_HI:SUB_LO] == SUB_JMP);
`else
    assign is_jmp = 1'b0;
`endif

    prog_counter #(.AW(AW)) u_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (pc_inc),
        .load     (pc_load),
        .load_val (bus.mem_data[AW-1:0]),
        .pc       (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_FETCH;
            ir_reg    <= '0;
            tmp_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (ir_load) begin
                ir_reg <= bus.mem_data;
            end
            if (tmp_load) begin
                tmp_reg <= tmp_val;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        mem_rd_next = 1'b0;
        rs_en       = 1'b0;
        rs_idx      = 2'd0;
        rw_next     = 1'b0;
        din_next    = '0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        ir_load     = 1'b0;
        tmp_load    = 1'b0;
        tmp_val     = '0;
        case (state_reg)
            ST_FETCH: begin
                mem_rd_next = 1'b1;
                if (bus.mem_ready) begin
                    ir_load    = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (ir_op(ir_reg))
                    OP_NOP:  state_next = is_jmp ? ST_FETCH_IMM : ST_FETCH;
                    OP_MOV:  state_next = ST_READ_SRC;
                    OP_LDI:  state_next = ST_FETCH_IMM;
                    default: state_next = ST_HALT;
                endcase
            end
            ST_READ_SRC: begin
                rs_en      = 1'b1;
                rs_idx     = ir_reg[SRC_HI:SRC_LO];
                tmp_load   = 1'b1;
                tmp_val    = bus.reg_dout;
                state_next = ST_WRITE_DST;
            end
            ST_FETCH_IMM: begin
                mem_rd_next = 1'b1;
                if (bus.mem_ready) begin
                    // A jump consumes its operand as the new PC and touches no register
                    if (is_jmp) begin
                        pc_load    = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        tmp_load   = 1'b1;
                        tmp_val    = bus.mem_data;
                        pc_inc     = 1'b1;
                        state_next = ST_WRITE_DST;
                    end
                end
            end
            ST_WRITE_DST: begin
                rs_en      = 1'b1;
                rs_idx     = ir_reg[DST_HI:DST_LO];
                rw_next    = 1'b1;
                din_next   = tmp_reg;
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_FETCH;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rs
            assign rs_onehot[gi] = rs_en && (rs_idx == gi[1:0]);
        end
    endgenerate

    // The state register resets to FETCH, so gate the read strobe while reset is held
    assign bus.mem_rd   = mem_rd_next & rst_n;
    assign bus.mem_addr = pc;
    assign bus.reg_rs   = rs_onehot;
    assign bus.reg_rw   = rw_next;
    assign bus.reg_din  = din_next;
    assign instr        = ir_reg;
    assign halted       = (state_reg == ST_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: program-memory and register-bank models
// around the DUT, hand-computed expectations cycle by cycle.
module tb_control_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] instr;
    logic       halted;
    logic [7:0] mem [256];
    logic [7:0] bank [4];
    logic       bank_clr;
    int         checks;
    int         failures;

    control_sequencer_if #(.AW(8), .DW(8)) bus ();

    control_sequencer #(.AW(8), .DW(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .instr  (instr),
        .halted (halted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign bus.mem_data = mem[bus.mem_addr];

    always_comb begin
        bus.reg_dout = 8'h00;
        case (bus.reg_rs)
            4'b0001: bus.reg_dout = bank[0];
            4'b0010: bus.reg_dout = bank[1];
            4'b0100: bus.reg_dout = bank[2];
            4'b1000: bus.reg_dout = bank[3];
            default: bus.reg_dout = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (bank_clr) begin
            for (int i = 0; i < 4; i++) bank[i] <= 8'h00;
        end else if (bus.reg_rw) begin
            case (bus.reg_rs)
                4'b0001: bank[0] <= bus.reg_din;
                4'b0010: bank[1] <= bus.reg_din;
                4'b0100: bank[2] <= bus.reg_din;
                4'b1000: bank[3] <= bus.reg_din;
                default: ;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h @%0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s obs=0x%0h @%0t", tag, obs, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int n;
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bank_clr       = 1'b1;
        bus.mem_ready  = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0]  = 8'h90; mem[1] = 8'hA5;     // LDI r1, 0xA5
        mem[2]  = 8'hA0; mem[3] = 8'h3C;     // LDI r2, 0x3C
        mem[4]  = 8'h48;                     // MOV r0 <- r2
        mem[5]  = 8'h00;                     // NOP (memory stalls)
        mem[6]  = 8'h55;                     // MOV r1 <- r1, sub=01
        mem[7]  = 8'h01; mem[8] = 8'h10;     // JMP 0x10 or two NOPs
        mem[9]  = 8'hC0;                     // HLT
        mem[16] = 8'hC0;                     // HLT (jump target)

        // Reset state
        repeat (2) step();
        chk("rst_mem_rd", bus.mem_rd, 0);
        chk("rst_reg_rs", bus.reg_rs, 0);
        chk("rst_halted", halted, 0);
        bank_clr = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("c1_addr", bus.mem_addr, 8'h00);
        chk("c1_rd", bus.mem_rd, 1);
        chk("c1_rs", bus.reg_rs, 0);
        chk("c1_rw", bus.reg_rw, 0);
        chk("c1_din", bus.reg_din, 0);
        chk("c1_instr", instr, 0);
        chk("c1_halted", halted, 0);

        // LDI r1, 0xA5
        step(); chk("ldi_dec_instr", instr, 8'h90); chk("ldi_dec_addr", bus.mem_addr, 1);
        chk("ldi_dec_rd", bus.mem_rd, 0);
        step(); chk("ldi_imm_rd", bus.mem_rd, 1); chk("ldi_imm_addr", bus.mem_addr, 1);
        step(); chk("ldi_wr_rs", bus.reg_rs, 4'b0010); chk("ldi_wr_rw", bus.reg_rw, 1);
        chk("ldi_wr_din", bus.reg_din, 8'hA5); chk("ldi_wr_pc", bus.mem_addr, 2);

        // LDI r2, 0x3C
        repeat (4) step();
        chk("ldi2_wr_rs", bus.reg_rs, 4'b0100); chk("ldi2_wr_din", bus.reg_din, 8'h3C);

        // MOV r0 <- r2
        step(); chk("mov_fetch_addr", bus.mem_addr, 4);
        step(); chk("mov_dec_instr", instr, 8'h48);
        step(); chk("mov_rd_rs", bus.reg_rs, 4'b0100); chk("mov_rd_rw", bus.reg_rw, 0);
        chk("mov_rd_din", bus.reg_din, 0);
        step(); chk("mov_wr_rs", bus.reg_rs, 4'b0001); chk("mov_wr_rw", bus.reg_rw, 1);
        chk("mov_wr_din", bus.reg_din, 8'h3C);

        // NOP fetch stalled for three cycles
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_rd", bus.mem_rd, 1);
            chk("stall_addr", bus.mem_addr, 5);
            chk("stall_rs", bus.reg_rs, 0);
        end
        step(); chk("stall_end_addr", bus.mem_addr, 5);
        bus.mem_ready = 1'b1;
        step(); chk("nop_dec_instr", instr, 8'h00); chk("nop_dec_addr", bus.mem_addr, 6);

        // MOV r1 <- r1 still reads then writes
        step(); chk("movs_fetch_addr", bus.mem_addr, 6);
        step(); chk("movs_dec_addr", bus.mem_addr, 7);
        step(); chk("movs_rd_rs", bus.reg_rs, 4'b0010); chk("movs_rd_rw", bus.reg_rw, 0);
        step(); chk("movs_wr_rs", bus.reg_rs, 4'b0010); chk("movs_wr_rw", bus.reg_rw, 1);
        chk("movs_wr_din", bus.reg_din, 8'hA5);

        // Encoding 0x01: JMP when enabled, otherwise NOP
        step(); chk("x01_fetch_addr", bus.mem_addr, 7);
        step(); chk("x01_dec_instr", instr, 8'h01);
`ifdef CTRL_JMP_EN
        step(); chk("jmp_imm_addr", bus.mem_addr, 8); chk("jmp_imm_rd", bus.mem_rd, 1);
        step(); chk("jmp_target", bus.mem_addr, 8'h10); chk("jmp_rs", bus.reg_rs, 0);
`else
        step(); chk("x01_nop_addr", bus.mem_addr, 8); chk("x01_nop_rd", bus.mem_rd, 1);
        step(); chk("x01_next_instr", instr, 8'h10);
`endif

        // HLT
        n = 0;
        while (!halted && n < 10) begin
            step();
            n++;
        end
        chk("hlt_reached", halted, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("hlt_rd", bus.mem_rd, 0);
            chk("hlt_rs", bus.reg_rs, 0);
        end
        chk("bank_r0", bank[0], 8'h3C);
        chk("bank_r1", bank[1], 8'hA5);
        chk("bank_r2", bank[2], 8'h3C);

        // Reset pulse during WRITE_DST must abort the write
        rst_n    = 1'b0;
        bank_clr = 1'b1;
        mem[1]   = 8'h5A;
        step(); step();
        bank_clr = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rst2_addr", bus.mem_addr, 0);
        repeat (3) step();
        chk("pre_abort_rs", bus.reg_rs, 4'b0010); chk("pre_abort_din", bus.reg_din, 8'h5A);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rs", bus.reg_rs, 0);
        chk("abort_rw", bus.reg_rw, 0);
        chk("abort_din", bus.reg_din, 0);
        chk("abort_pc", bus.mem_addr, 0);
        chk("abort_halted", halted, 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("restart_addr", bus.mem_addr, 0);
        chk("restart_rd", bus.mem_rd, 1);
        chk("no_partial_wr", bank[1], 8'h00);

        // PC wrap: LDI at 0xFF takes its immediate from address 0
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0]   = 8'h0F;
        mem[255] = 8'hB0;
        step(); step();
        rst_n = 1'b1;
        #1;
        n = 0;
        while (!(bus.mem_addr == 8'hFF && bus.mem_rd) && n < 1000) begin
            step();
            n++;
        end
        chk("wrap_reach_ff", {bus.mem_addr, bus.mem_rd}, {8'hFF, 1'b1});
        step(); chk("wrap_dec_instr", instr, 8'hB0); chk("wrap_pc0", bus.mem_addr, 0);
        step(); chk("wrap_imm_addr", bus.mem_addr, 0); chk("wrap_imm_rd", bus.mem_rd, 1);
        step(); chk("wrap_wr_rs", bus.reg_rs, 4'b1000); chk("wrap_wr_din", bus.reg_din, 8'h0F);
        chk("wrap_pc1", bus.mem_addr, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
